// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe environment and the cleaning robot FSM:
// orientation and cell encodings, default map size, and the turn rule.
package pipe_pkg;

    localparam logic [1:0] NORTH = 2'b00;
    localparam logic [1:0] SOUTH = 2'b01;
    localparam logic [1:0] EAST  = 2'b10;
    localparam logic [1:0] WEST  = 2'b11;

    localparam logic [2:0] CELL_EMPTY   = 3'd0;
    localparam logic [2:0] CELL_WALL    = 3'd1;
    localparam logic [2:0] CELL_BARRIER = 3'd2;
    localparam logic [2:0] CELL_DEBRIS  = 3'd7;

    localparam int ROWS_DEFAULT = 10;
    localparam int COLS_DEFAULT = 20;

    // A left turn walks N -> W -> S -> E -> N.
    function automatic logic [1:0] rotateLeft(input logic [1:0] o);
        case (o)
            NORTH:   return WEST;
            WEST:    return SOUTH;
            SOUTH:   return EAST;
            default: return NORTH;
        endcase
    endfunction

endpackage

// File: rtl/pipe_neighbour_addr.sv
// Combinational neighbour addressing: from the robot pose, produce the
// coordinates of the cell ahead and the cell to the left, each with a bit
// saying whether it lies inside the 1..ROWS x 1..COLS map. Arithmetic is
// done one bit wider so that stepping off row/column 0 cannot wrap back
// into a legal coordinate.
module pipe_neighbour_addr
    import pipe_pkg::*;
#(
    parameter int ROWS = ROWS_DEFAULT,
    parameter int COLS = COLS_DEFAULT
) (
    input  logic [3:0] row_i,
    input  logic [4:0] col_i,
    input  logic [1:0] orient_i,
    output logic [3:0] aheadRow_o,
    output logic [4:0] aheadCol_o,
    output logic       aheadValid_o,
    output logic [3:0] leftRow_o,
    output logic [4:0] leftCol_o,
    output logic       leftValid_o,
    output logic       curValid_o
);

    localparam logic [4:0] ROWS_LIM = 5'(ROWS);
    localparam logic [5:0] COLS_LIM = 6'(COLS);

    logic [4:0] rowExt;
    logic [5:0] colExt;
    logic [4:0] rowMinus;
    logic [4:0] rowPlus;
    logic [5:0] colMinus;
    logic [5:0] colPlus;
    logic [4:0] aheadRowExt;
    logic [5:0] aheadColExt;
    logic [4:0] leftRowExt;
    logic [5:0] leftColExt;

    assign rowExt   = {1'b0, row_i};
    assign colExt   = {1'b0, col_i};
    assign rowMinus = rowExt - 5'd1;
    assign rowPlus  = rowExt + 5'd1;
    assign colMinus = colExt - 6'd1;
    assign colPlus  = colExt + 6'd1;

    // Select the ahead and left offsets for the current heading.
    always_comb begin
        aheadRowExt = rowExt;
        aheadColExt = colExt;
        leftRowExt  = rowExt;
        leftColExt  = colExt;
        case (orient_i)
            NORTH: begin
                aheadRowExt = rowMinus;
                leftColExt  = colMinus;
            end
            SOUTH: begin
                aheadRowExt = rowPlus;
                leftColExt  = colPlus;
            end
            EAST: begin
                aheadColExt = colPlus;
                leftRowExt  = rowMinus;
            end
            default: begin
                aheadColExt = colMinus;
                leftRowExt  = rowPlus;
            end
        endcase
    end

    assign aheadValid_o = (aheadRowExt != 5'd0) && (aheadRowExt <= ROWS_LIM) &&
                          (aheadColExt != 6'd0) && (aheadColExt <= COLS_LIM);
    assign leftValid_o  = (leftRowExt != 5'd0) && (leftRowExt <= ROWS_LIM) &&
                          (leftColExt != 6'd0) && (leftColExt <= COLS_LIM);
    assign curValid_o   = (rowExt != 5'd0) && (rowExt <= ROWS_LIM) &&
                          (colExt != 6'd0) && (colExt <= COLS_LIM);

    assign aheadRow_o = aheadRowExt[3:0];
    assign aheadCol_o = aheadColExt[4:0];
    assign leftRow_o  = leftRowExt[3:0];
    assign leftCol_o  = leftColExt[4:0];

endmodule

// File: rtl/pipe_env_model.sv
// Pipe environment model sitting upstream of the cleaning robot. Holds the
// cell map and the robot pose, turns the robot's front/turn/remove commands
// into pose and map updates, and presents head/left/under/barrier sensors
// decoded purely from registered state.
module pipe_env_model
    import pipe_pkg::*;
#(
    parameter int ROWS          = ROWS_DEFAULT,
    parameter int COLS          = COLS_DEFAULT,
    parameter int REMOVE_CYCLES = 3,
    parameter int MOVE_W        = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cell_we,
    input  logic [3:0]        cell_row,
    input  logic [4:0]        cell_col,
    input  logic [2:0]        cell_wdata,
    input  logic              start,
    input  logic [3:0]        init_row,
    input  logic [4:0]        init_col,
    input  logic [1:0]        init_orient,
    input  logic              front,
    input  logic              turn,
    input  logic              remove,
    output logic              head,
    output logic              left,
    output logic              under,
    output logic              barrier,
    output logic [3:0]        pos_row,
    output logic [4:0]        pos_col,
    output logic [1:0]        orient,
    output logic [MOVE_W-1:0] move_count,
    output logic              collide,
    output logic              out_of_map
);

    localparam int         CELLS    = ROWS * COLS;
    localparam int         IDX_W    = $clog2(CELLS);
    localparam int         REM_W    = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
    localparam logic [REM_W-1:0] REM_LAST = REM_W'(REMOVE_CYCLES - 1);
    localparam logic [3:0] ROWS_LIM = 4'(ROWS);
    localparam logic [4:0] COLS_LIM = 5'(COLS);

    // Row-major flat address; only meaningful for in-map coordinates.
    function automatic logic [IDX_W-1:0] cellIdx(input logic [3:0] r, input logic [4:0] c);
        return IDX_W'((int'(r) - 1) * COLS + (int'(c) - 1));
    endfunction

    logic [2:0]        map_q [CELLS];

    logic [3:0]        posRow_q,    posRow_d;
    logic [4:0]        posCol_q,    posCol_d;
    logic [1:0]        orient_q,    orient_d;
    logic [MOVE_W-1:0] moveCount_q, moveCount_d;
    logic              collide_q,   collide_d;
    logic              outOfMap_q,  outOfMap_d;
    logic [REM_W-1:0]  remCount_q,  remCount_d;

    logic [3:0]        aheadRow;
    logic [4:0]        aheadCol;
    logic              aheadValid;
    logic [3:0]        leftRow;
    logic [4:0]        leftCol;
    logic              leftValid;
    logic              curValid;

    logic [2:0]        aheadCell;
    logic [2:0]        leftCell;
    logic [2:0]        curCell;

    logic              moveApplied;
    logic              clearEn;
    logic              writeEn;
    logic              initInMap;

    pipe_neighbour_addr #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) uNeighbour (
        .row_i       (posRow_q),
        .col_i       (posCol_q),
        .orient_i    (orient_q),
        .aheadRow_o  (aheadRow),
        .aheadCol_o  (aheadCol),
        .aheadValid_o(aheadValid),
        .leftRow_o   (leftRow),
        .leftCol_o   (leftCol),
        .leftValid_o (leftValid),
        .curValid_o  (curValid)
    );

    // Off-map neighbours read as wall so they block moves and never look like barriers.
    assign aheadCell = aheadValid ? map_q[cellIdx(aheadRow, aheadCol)] : CELL_WALL;
    assign leftCell  = leftValid  ? map_q[cellIdx(leftRow, leftCol)]   : CELL_WALL;
    assign curCell   = curValid   ? map_q[cellIdx(posRow_q, posCol_q)] : CELL_EMPTY;

    assign head    = (aheadCell == CELL_WALL);
    assign left    = (leftCell == CELL_WALL);
    assign barrier = (aheadCell == CELL_BARRIER);
    assign under   = (curCell == CELL_DEBRIS);

    assign pos_row    = posRow_q;
    assign pos_col    = posCol_q;
    assign orient     = orient_q;
    assign move_count = moveCount_q;
    assign collide    = collide_q;
    assign out_of_map = outOfMap_q;

    assign writeEn   = cell_we && (cell_row != 4'd0) && (cell_row <= ROWS_LIM) &&
                       (cell_col != 5'd0) && (cell_col <= COLS_LIM);
    assign initInMap = (init_row != 4'd0) && (init_row <= ROWS_LIM) &&
                       (init_col != 5'd0) && (init_col <= COLS_LIM);

    // Next pose, counters and removal decision; start outranks robot commands.
    always_comb begin
        posRow_d    = posRow_q;
        posCol_d    = posCol_q;
        orient_d    = orient_q;
        moveCount_d = moveCount_q;
        collide_d   = collide_q;
        outOfMap_d  = outOfMap_q;
        remCount_d  = remCount_q;
        moveApplied = 1'b0;
        clearEn     = 1'b0;

        if (start) begin
            posRow_d    = init_row;
            posCol_d    = init_col;
            orient_d    = init_orient;
            moveCount_d = '0;
            collide_d   = 1'b0;
            outOfMap_d  = !initInMap;
            remCount_d  = '0;
        end else begin
            if (remove) begin
                if (remCount_q == REM_LAST) begin
                    remCount_d = '0;
                    clearEn    = aheadValid;
                end else begin
                    remCount_d = remCount_q + 1'b1;
                end
            end

            if (!outOfMap_q) begin
                if (front) begin
                    if (aheadValid && (aheadCell != CELL_WALL) && (aheadCell != CELL_BARRIER)) begin
                        posRow_d    = aheadRow;
                        posCol_d    = aheadCol;
                        moveApplied = 1'b1;
                    end else begin
                        collide_d = 1'b1;
                    end
                end else if (turn) begin
                    orient_d    = rotateLeft(orient_q);
                    moveApplied = 1'b1;
                end
            end

            if (moveApplied) begin
                remCount_d = '0;
                if (moveCount_q != '1) begin
                    moveCount_d = moveCount_q + 1'b1;
                end
            end
        end
    end

    // Pose, counter and flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            posRow_q    <= 4'd1;
            posCol_q    <= 5'd1;
            orient_q    <= NORTH;
            moveCount_q <= '0;
            collide_q   <= 1'b0;
            outOfMap_q  <= 1'b0;
            remCount_q  <= '0;
        end else begin
            posRow_q    <= posRow_d;
            posCol_q    <= posCol_d;
            orient_q    <= orient_d;
            moveCount_q <= moveCount_d;
            collide_q   <= collide_d;
            outOfMap_q  <= outOfMap_d;
            remCount_q  <= remCount_d;
        end
    end

    // Map storage; the host write is issued last so it overrides a same-cell removal clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++) begin
                map_q[i] <= CELL_EMPTY;
            end
        end else begin
            if (clearEn) begin
                map_q[cellIdx(aheadRow, aheadCol)] <= CELL_EMPTY;
            end
            if (writeEn) begin
                map_q[cellIdx(cell_row, cell_col)] <= cell_wdata;
            end
        end
    end

endmodule

// File: tb/tb_pipe_env_model.sv
// Testbench for pipe_env_model: a grid-level reference model predicts every
// post-edge output, the stimulus side queues predictions, and a monitor pops
// and compares them one clock edge later.
module tb_pipe_env_model;

    localparam int ROWS = 10;
    localparam int COLS = 20;
    localparam int RC   = 3;
    localparam int MW   = 9;

    typedef struct {
        logic       rst;
        logic       st;
        logic       we;
        logic [3:0] wr;
        logic [4:0] wc;
        logic [2:0] wd;
        logic [3:0] ir;
        logic [4:0] ic;
        logic [1:0] io;
        logic       f;
        logic       t;
        logic       rm;
    } stim_t;

    typedef struct {
        logic          head;
        logic          left;
        logic          under;
        logic          barrier;
        logic [3:0]    row;
        logic [4:0]    col;
        logic [1:0]    ori;
        logic [MW-1:0] mc;
        logic          collide;
        logic          oom;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          cell_we;
    logic [3:0]    cell_row;
    logic [4:0]    cell_col;
    logic [2:0]    cell_wdata;
    logic          start;
    logic [3:0]    init_row;
    logic [4:0]    init_col;
    logic [1:0]    init_orient;
    logic          front;
    logic          turn;
    logic          remove;
    logic          head;
    logic          left;
    logic          under;
    logic          barrier;
    logic [3:0]    pos_row;
    logic [4:0]    pos_col;
    logic [1:0]    orient;
    logic [MW-1:0] move_count;
    logic          collide;
    logic          out_of_map;

    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];

    // Reference model state: map indexed by (row, col), pose as plain integers.
    int mMap [1:ROWS][1:COLS];
    int mRow, mCol, mOri, mMoves, mRem;
    bit mCollide, mOom;

    // Heading index: 0 north, 1 south, 2 east, 3 west.
    int aheadDr [4] = '{-1, 1, 0, 0};
    int aheadDc [4] = '{0, 0, 1, -1};
    int leftDr  [4] = '{0, 0, -1, 1};
    int leftDc  [4] = '{-1, 1, 0, 0};
    int rotTbl  [4] = '{3, 2, 0, 1};

    pipe_env_model #(
        .ROWS(ROWS),
        .COLS(COLS),
        .REMOVE_CYCLES(RC),
        .MOVE_W(MW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cell_we    (cell_we),
        .cell_row   (cell_row),
        .cell_col   (cell_col),
        .cell_wdata (cell_wdata),
        .start      (start),
        .init_row   (init_row),
        .init_col   (init_col),
        .init_orient(init_orient),
        .front      (front),
        .turn       (turn),
        .remove     (remove),
        .head       (head),
        .left       (left),
        .under      (under),
        .barrier    (barrier),
        .pos_row    (pos_row),
        .pos_col    (pos_col),
        .orient     (orient),
        .move_count (move_count),
        .collide    (collide),
        .out_of_map (out_of_map)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic bit onMap(int r, int c);
        return (r >= 1) && (r <= ROWS) && (c >= 1) && (c <= COLS);
    endfunction

    // Anything outside the map reads as a wall (code 1).
    function automatic int cellAt(int r, int c);
        if (!onMap(r, c)) return 1;
        return mMap[r][c];
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Advance the reference model by one clock edge.
    task automatic modelStep(input stim_t s);
        int ar, ac, code;
        bit doClear, moved;
        ar      = mRow + aheadDr[mOri];
        ac      = mCol + aheadDc[mOri];
        doClear = 0;
        moved   = 0;
        if (s.rst) begin
            for (int r = 1; r <= ROWS; r++)
                for (int c = 1; c <= COLS; c++)
                    mMap[r][c] = 0;
            mRow = 1; mCol = 1; mOri = 0;
            mMoves = 0; mRem = 0; mCollide = 0; mOom = 0;
            return;
        end
        if (s.st) begin
            mRow = int'(s.ir); mCol = int'(s.ic); mOri = int'(s.io);
            mOom = !onMap(mRow, mCol);
            mCollide = 0; mMoves = 0; mRem = 0;
        end else begin
            if (s.rm) begin
                mRem++;
                if (mRem == RC) begin
                    mRem = 0;
                    doClear = onMap(ar, ac);
                end
            end
            if (!mOom) begin
                if (s.f) begin
                    code = cellAt(ar, ac);
                    if (onMap(ar, ac) && code != 1 && code != 2) begin
                        mRow = ar; mCol = ac; moved = 1;
                    end else begin
                        mCollide = 1;
                    end
                end else if (s.t) begin
                    mOri = rotTbl[mOri];
                    moved = 1;
                end
            end
            if (moved) begin
                mRem = 0;
                if (mMoves < (1 << MW) - 1) mMoves++;
            end
        end
        if (doClear) mMap[ar][ac] = 0;
        if (s.we && onMap(int'(s.wr), int'(s.wc))) mMap[int'(s.wr)][int'(s.wc)] = int'(s.wd);
    endtask

    function automatic exp_t modelOutputs();
        exp_t e;
        int ahead, lft;
        ahead     = cellAt(mRow + aheadDr[mOri], mCol + aheadDc[mOri]);
        lft       = cellAt(mRow + leftDr[mOri], mCol + leftDc[mOri]);
        e.head    = (ahead == 1);
        e.left    = (lft == 1);
        e.barrier = (ahead == 2);
        e.under   = onMap(mRow, mCol) && (cellAt(mRow, mCol) == 7);
        e.row     = 4'(mRow);
        e.col     = 5'(mCol);
        e.ori     = 2'(mOri);
        e.mc      = MW'(mMoves);
        e.collide = mCollide;
        e.oom     = mOom;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the predicted result.
    task automatic applyStimulus(input stim_t s);
        @(negedge clock);
        reset       = s.rst;
        start       = s.st;
        cell_we     = s.we;
        cell_row    = s.wr;
        cell_col    = s.wc;
        cell_wdata  = s.wd;
        init_row    = s.ir;
        init_col    = s.ic;
        init_orient = s.io;
        front       = s.f;
        turn        = s.t;
        remove      = s.rm;
        modelStep(s);
        expQ.push_back(modelOutputs());
    endtask

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareVal("head",       32'(head),       32'(e.head));
        compareVal("left",       32'(left),       32'(e.left));
        compareVal("under",      32'(under),      32'(e.under));
        compareVal("barrier",    32'(barrier),    32'(e.barrier));
        compareVal("pos_row",    32'(pos_row),    32'(e.row));
        compareVal("pos_col",    32'(pos_col),    32'(e.col));
        compareVal("orient",     32'(orient),     32'(e.ori));
        compareVal("move_count", 32'(move_count), 32'(e.mc));
        compareVal("collide",    32'(collide),    32'(e.collide));
        compareVal("out_of_map", 32'(out_of_map), 32'(e.oom));
    endtask

    task automatic doReset();
        stim_t s;
        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
    endtask

    task automatic doStart(input int r, input int c, input int o);
        stim_t s;
        s = idleStim();
        s.st = 1'b1; s.ir = 4'(r); s.ic = 5'(c); s.io = 2'(o);
        applyStimulus(s);
    endtask

    task automatic doWrite(input int r, input int c, input int d);
        stim_t s;
        s = idleStim();
        s.we = 1'b1; s.wr = 4'(r); s.wc = 5'(c); s.wd = 3'(d);
        applyStimulus(s);
    endtask

    task automatic doCmd(input bit f, input bit t, input bit rm);
        stim_t s;
        s = idleStim();
        s.f = f; s.t = t; s.rm = rm;
        applyStimulus(s);
    endtask

    // Monitor: one edge after each queued prediction, compare it with the DUT.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    // Global watchdog so a stuck run still ends with a visible failure.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then a randomized closed-loop run.
    initial begin
        stim_t s;
        int guard;
        reset = 1'b0; start = 1'b0; cell_we = 1'b0; cell_row = '0; cell_col = '0;
        cell_wdata = '0; init_row = '0; init_col = '0; init_orient = '0;
        front = 1'b0; turn = 1'b0; remove = 1'b0;

        doReset();
        doStart(5, 10, 2);
        repeat (3) doCmd(1, 0, 0);

        doStart(1, 1, 0);
        doCmd(1, 0, 0);
        repeat (4) doCmd(0, 1, 0);

        doWrite(5, 11, 2);
        doStart(5, 10, 2);
        repeat (3) doCmd(0, 0, 1);
        doCmd(1, 0, 0);

        doWrite(5, 11, 2);
        doStart(5, 10, 2);
        doCmd(0, 0, 1);
        doCmd(0, 0, 1);
        doCmd(0, 1, 1);
        doCmd(0, 0, 1);

        doWrite(5, 10, 7);
        doStart(5, 10, 0);
        doStart(10, 5, 1);

        doWrite(5, 11, 2);
        doStart(5, 10, 2);
        doCmd(0, 0, 1);
        doCmd(0, 0, 1);
        s = idleStim();
        s.rm = 1'b1; s.we = 1'b1; s.wr = 4'd5; s.wc = 5'd11; s.wd = 3'd1;
        applyStimulus(s);
        doStart(0, 5, 0);
        doCmd(1, 0, 0);
        doCmd(0, 1, 0);

        doWrite(11, 3, 1);
        doWrite(0, 0, 1);
        doWrite(3, 21, 1);
        doStart(0, 5, 1);
        doWrite(1, 5, 2);
        repeat (3) doCmd(0, 0, 1);

        doReset();
        doCmd(0, 0, 1);
        doReset();
        doCmd(0, 0, 1);

        doStart(2, 2, 0);
        repeat (515) doCmd(0, 1, 0);
        doCmd(1, 0, 0);

        doReset();
        for (int n = 0; n < 3000; n++) begin
            s = idleStim();
            s.rst = ($urandom_range(0, 299) == 0);
            s.st  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) begin
                s.ir = 4'($urandom_range(0, 15));
                s.ic = 5'($urandom_range(0, 31));
            end else begin
                s.ir = 4'($urandom_range(1, ROWS));
                s.ic = 5'($urandom_range(1, COLS));
            end
            s.io = 2'($urandom_range(0, 3));
            s.we = ($urandom_range(0, 3) == 0);
            s.wr = 4'($urandom_range(0, ROWS + 1));
            s.wc = 5'($urandom_range(0, COLS + 1));
            case ($urandom_range(0, 5))
                0, 1:    s.wd = 3'd0;
                2:       s.wd = 3'd1;
                3:       s.wd = 3'd2;
                4:       s.wd = 3'd7;
                default: s.wd = 3'($urandom_range(3, 6));
            endcase
            s.f  = ($urandom_range(0, 2) == 0);
            s.t  = ($urandom_range(0, 2) == 0);
            s.rm = ($urandom_range(0, 1) == 0);
            applyStimulus(s);
        end

        guard = 0;
        while (expQ.size() > 0 && guard < 10) begin
            @(posedge clock);
            guard++;
        end
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
